// File: rtl/imem_prog_loader.sv
// Instruction memory with a streaming program loader and a registered fetch port.
// Optional macro IMEM_PARITY_EN adds a per-word even-parity bit checked on fetch.
module imem_prog_loader #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 128,
  parameter int unsigned       ADDR_W    = 7,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'h9000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fetch_req,
  input  logic [31:0]       PC,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic [ADDR_W:0]   prog_len,
  output logic [1:0]        state_o,
  output logic              parity_err
);

  localparam int unsigned PTR_W = ADDR_W + 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt, prog_len_nxt;
  logic               wr_ready_nxt;
  logic               beat, mem_we;
  logic               fetch_ok, range_fault, par_bad;
  logic [ADDR_W-1:0]  rd_idx;
  logic [MEM_W-1:0]   wr_word, rd_word;
  logic [MEM_W-1:0]   mem [DEPTH];

  assign state_o  = state;
  assign beat     = wr_valid & wr_ready;
  assign rd_idx   = PC[ADDR_W-1:0];
  assign rd_word  = mem[rd_idx];
  assign fetch_ok = fetch_req & (state == RUN);
  assign range_fault = (|PC[31:ADDR_W]) | ({1'b0, rd_idx} >= prog_len);

`ifdef IMEM_PARITY_EN
  // Stored bit makes the whole word even parity, so any odd flip reads back as 1.
  assign wr_word = {^wr_data, wr_data};
  assign par_bad = ^rd_word;
`else
  assign wr_word = wr_data;
  assign par_bad = 1'b0;
`endif

  // Loader FSM next-state; load_start dominates and discards a coincident beat.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    prog_len_nxt = prog_len;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          wr_ptr_nxt = '0;
        end else begin
          mem_we = beat;
          if (beat) wr_ptr_nxt = wr_ptr + PTR_W'(1);
          if (load_done || (beat && (wr_ptr == PTR_W'(DEPTH - 1)))) begin
            state_nxt    = RUN;
            prog_len_nxt = beat ? wr_ptr + PTR_W'(1) : wr_ptr;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // wr_ptr never reaches DEPTH while in LOAD, so ready simply tracks the state.
    wr_ready_nxt = (state_nxt == LOAD);
  end

  // State, pointer and registered fetch response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      prog_len    <= '0;
      wr_ready    <= 1'b0;
      instruction <= HALT_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      prog_len <= prog_len_nxt;
      wr_ready <= wr_ready_nxt;
      if (fetch_ok) begin
        instr_valid <= 1'b1;
        addr_fault  <= range_fault;
        instruction <= (range_fault | par_bad) ? HALT_WORD : rd_word[DATA_W-1:0];
      end else begin
        instr_valid <= 1'b0;
        addr_fault  <= 1'b0;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= fetch_ok & ~range_fault & par_bad;
  end
  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

  // Program storage, not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomized bench for imem_prog_loader against a transaction-level model of the loader and fetch port.
module tb_imem_prog_loader;
  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] HALT  = 32'h9000_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        load_start = 1'b0, load_done = 1'b0, wr_valid = 1'b0, fetch_req = 1'b0;
  logic [31:0] wr_data = '0, PC = '0;
  logic        wr_ready, instr_valid, addr_fault, parity_err;
  logic [31:0] instruction;
  logic [7:0]  prog_len;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  imem_prog_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .fetch_req(fetch_req), .PC(PC), .instruction(instruction),
    .instr_valid(instr_valid), .addr_fault(addr_fault), .prog_len(prog_len),
    .state_o(state_o), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 loading, 2 running; program kept as a plain word array.
  int          m_mode = 0;
  int unsigned m_ptr = 0, m_len = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_bad [DEPTH];
  logic [31:0] e_instr = HALT;
  bit          e_valid = 1'b0, e_fault = 1'b0, e_par = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    int unsigned p, len;
    int          mode;
    if (!reset) begin
      m_mode <= 0; m_ptr <= 0; m_len <= 0;
      e_instr <= HALT; e_valid <= 1'b0; e_fault <= 1'b0; e_par <= 1'b0;
    end else begin
      if (m_mode == 2 && fetch_req) begin
        e_valid <= 1'b1;
        if (PC >= m_len) begin
          e_instr <= HALT; e_fault <= 1'b1; e_par <= 1'b0;
        end else if (m_bad[PC]) begin
          e_instr <= HALT; e_fault <= 1'b0; e_par <= 1'b1;
        end else begin
          e_instr <= m_mem[PC]; e_fault <= 1'b0; e_par <= 1'b0;
        end
      end else begin
        e_valid <= 1'b0; e_fault <= 1'b0; e_par <= 1'b0;
      end
      mode = m_mode; p = m_ptr; len = m_len;
      if (load_start) begin
        mode = 1; p = 0;
      end else if (mode == 1) begin
        if (wr_valid) begin
          m_mem[p] <= wr_data;
          m_bad[p] <= 1'b0;
          p = p + 1;
        end
        if (load_done || p == DEPTH) begin
          mode = 2; len = p;
        end
      end
      m_mode <= mode; m_ptr <= p; m_len <= len;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("state", 64'(state_o), 64'(m_mode));
      check("wr_ready", 64'(wr_ready), 64'(m_mode == 1));
      check("prog_len", 64'(prog_len), 64'(m_len));
      check("instr_valid", 64'(instr_valid), 64'(e_valid));
      check("instruction", 64'(instruction), 64'(e_instr));
      if (instr_valid) check("addr_fault", 64'(addr_fault), 64'(e_fault));
      check("parity_err", 64'(parity_err), 64'(e_par));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; PC = a;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic load_prog(input int n, input logic [31:0] base);
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1; wr_data = base + 32'(i); step();
    end
    wr_valid = 1'b0; load_done = 1'b1; step(); load_done = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    #1;
    check("rst_state", 64'(state_o), 64'(2'b00));
    check("rst_instr", 64'(instruction), 64'(32'h9000_0000));
    check("rst_wr_ready", 64'(wr_ready), 64'(1'b0));
    check("rst_prog_len", 64'(prog_len), 64'(0));
    reset = 1'b1;
    step();
    fetch(32'd0);
    check("idle_fetch_valid", 64'(instr_valid), 64'(1'b0));

    // 8-word program
    load_prog(8, 32'h1010_0000);
    fetch(32'd2);
    check("pc2_instr", 64'(instruction), 64'(32'h1010_0002));
    check("pc2_valid", 64'(instr_valid), 64'(1'b1));
    check("pc2_fault", 64'(addr_fault), 64'(1'b0));
    check("pc2_len", 64'(prog_len), 64'(8));
    fetch(32'd8);
    check("pc8_instr", 64'(instruction), 64'(32'h9000_0000));
    check("pc8_fault", 64'(addr_fault), 64'(1'b1));
    fetch(32'h0000_0100);
    check("pc100_instr", 64'(instruction), 64'(32'h9000_0000));
    check("pc100_fault", 64'(addr_fault), 64'(1'b1));

    fetch(32'd3);
`ifdef IMEM_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    m_bad[3] = 1'b1;
    fetch(32'd3);
    check("par_err", 64'(parity_err), 64'(1'b1));
    check("par_instr", 64'(instruction), 64'(32'h9000_0000));
    check("par_fault", 64'(addr_fault), 64'(1'b0));
`else
    check("par_off", 64'(parity_err), 64'(1'b0));
    check("pc3_instr", 64'(instruction), 64'(32'h1010_0003));
`endif

    // Full-depth stream with wr_valid held high
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      wr_valid = 1'b1; wr_data = 32'hA000_0000 + 32'(i); step();
    end
    wr_valid = 1'b0;
    check("full_ready", 64'(wr_ready), 64'(1'b0));
    check("full_state", 64'(state_o), 64'(2'b10));
    check("full_len", 64'(prog_len), 64'(128));
    fetch(32'd127);
    check("full_pc127", 64'(instruction), 64'(32'hA000_007F));

    // load_done coinciding with the beat at wr_ptr=5
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 32'h5500_0000 + 32'(i); step();
    end
    wr_data = 32'h5500_0005; load_done = 1'b1; step();
    wr_valid = 1'b0; load_done = 1'b0;
    check("same_len", 64'(prog_len), 64'(6));
    check("same_state", 64'(state_o), 64'(2'b10));
    fetch(32'd5);
    check("same_pc5", 64'(instruction), 64'(32'h5500_0005));
    load_start = 1'b1; step(); load_start = 1'b0;
    check("reload_state", 64'(state_o), 64'(2'b01));
    fetch(32'd1);
    check("load_fetch_valid", 64'(instr_valid), 64'(1'b0));
    check("load_fetch_hold", 64'(instruction), 64'(32'h5500_0005));
    load_done = 1'b1; step(); load_done = 1'b0;
    check("empty_len", 64'(prog_len), 64'(0));
    fetch(32'd0);
    check("empty_fault", 64'(addr_fault), 64'(1'b1));
    check("empty_instr", 64'(instruction), 64'(32'h9000_0000));

    // Reset in the middle of a load
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = $urandom; step();
    end
    wr_valid = 1'b0; reset = 1'b0;
    #2;
    check("mid_rst_state", 64'(state_o), 64'(2'b00));
    check("mid_rst_instr", 64'(instruction), 64'(32'h9000_0000));
    check("mid_rst_ready", 64'(wr_ready), 64'(1'b0));
    check("mid_rst_len", 64'(prog_len), 64'(0));
    step(); reset = 1'b1; step();

    // Randomized loads and fetches
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(0, 140));
      load_start = 1'b1; step(); load_start = 1'b0;
      for (int i = 0; i < n; ) begin
        wr_valid  = ($urandom_range(0, 3) != 0);
        wr_data   = $urandom;
        fetch_req = 1'($urandom_range(0, 1));
        PC        = $urandom_range(0, 200);
        step();
        if (wr_valid) i++;
      end
      wr_valid = 1'($urandom_range(0, 1)); wr_data = $urandom;
      fetch_req = 1'b0; load_done = 1'b1; step();
      load_done = 1'b0; wr_valid = 1'b0;
      repeat (30) begin
        fetch_req = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       PC = $urandom_range(0, 127);
          1:       PC = $urandom_range(0, 140);
          2:       PC = $urandom;
          default: PC = $urandom_range(0, 7);
        endcase
        load_done = ($urandom_range(0, 15) == 0);
        step();
      end
      fetch_req = 1'b0; load_done = 1'b0;
    end

    step();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
